// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// The optional BREAK state is only entered when UART_RX_BREAK_DETECT_EN is defined.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Tick offsets from P/2: sampled_bit is valid at SP, checker results arrive at EV.
  localparam int          SP_OFFSET    = 2;
  localparam int          EV_OFFSET    = 3;
  localparam int unsigned MIN_PRESCALE = 8;
  localparam int          BIT_CNT_W    = 4;

  function automatic int unsigned eff_prescale(input int unsigned p);
    return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// The oversampling ratio is captured on start_i and held for the whole frame.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic                      en_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
  output logic [PRESCALE_WIDTH-1:0] edge_nxt_o,
  output logic [PRESCALE_WIDTH-1:0] prescale_o,
  output logic [BIT_CNT_W-1:0]      bit_cnt_o
);

  localparam int PW = PRESCALE_WIDTH;

  logic [PW-1:0]        edge_q, edge_d;
  logic [PW-1:0]        p_q, p_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 at_last;

  assign at_last = (edge_q == (p_q - PW'(1)));

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    p_d    = p_q;
    if (start_i) begin
      edge_d = '0;
      bit_d  = '0;
      p_d    = PW'(eff_prescale(32'(prescale_i)));
    end else if (clear_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (en_i) begin
      if (at_last) begin
        edge_d = '0;
        bit_d  = bit_q + BIT_CNT_W'(1);
      end else begin
        edge_d = edge_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      edge_q <= '0;
      bit_q  <= '0;
      p_q    <= PW'(MIN_PRESCALE);
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
      p_q    <= p_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign edge_nxt_o = edge_d;
  assign prescale_o = p_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: sequences start/data/parity/stop and strobes the checkers.
// Define UART_RX_BREAK_DETECT_EN to report all-zero frames as a line break (break_det).
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      sampled_bit,
  input  logic                      start_bit_error,
  input  logic                      par_err,
  input  logic                      stop_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]      bit_cnt,
  output logic                      sampler_en,
  output logic                      start_chk_en,
  output logic                      par_chk_en,
  output logic                      stop_chk_en,
  output logic                      deser_en,
  output logic                      data_valid,
  output logic                      framing_error,
  output logic                      break_det
);

  localparam int PW = PRESCALE_WIDTH;

  rx_state_e     state_q, state_d;
  logic          par_err_q, par_err_d;
  logic [PW-1:0] p_lat, edge_nxt, sp_tick, ev_tick, last_tick;
  logic          start_frame, clear_cnt, in_frame;
  logic          at_sp, at_ev, at_last, at_sp_nxt;

  logic sampler_en_q, sampler_en_d;
  logic start_chk_en_q, start_chk_en_d;
  logic par_chk_en_q, par_chk_en_d;
  logic stop_chk_en_q, stop_chk_en_d;
  logic deser_en_q, deser_en_d;
  logic data_valid_q, data_valid_d;
  logic framing_error_q, framing_error_d;
  logic break_det_q, break_det_d;

`ifdef UART_RX_BREAK_DETECT_EN
  logic seen_one_q, seen_one_d;
`else
  logic unused_sampled_bit;
  assign unused_sampled_bit = sampled_bit;
`endif

  assign sp_tick   = (p_lat >> 1) + PW'(SP_OFFSET);
  assign ev_tick   = (p_lat >> 1) + PW'(EV_OFFSET);
  assign last_tick = p_lat - PW'(1);
  assign at_sp     = (edge_cnt == sp_tick);
  assign at_ev     = (edge_cnt == ev_tick);
  assign at_last   = (edge_cnt == last_tick);
  assign at_sp_nxt = (edge_nxt == sp_tick);

  assign in_frame    = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign start_frame = (state_q == ST_IDLE) && !rx_in;
  assign clear_cnt   = (state_d == ST_IDLE) || (state_d == ST_BREAK);

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_counter (
    .clk_i      (clk),
    .rst_i      (reset),
    .start_i    (start_frame),
    .clear_i    (clear_cnt),
    .en_i       (in_frame),
    .prescale_i (prescale),
    .edge_cnt_o (edge_cnt),
    .edge_nxt_o (edge_nxt),
    .prescale_o (p_lat),
    .bit_cnt_o  (bit_cnt)
  );

  always_comb begin
    state_d         = state_q;
    par_err_d       = par_err_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;
    break_det_d     = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    seen_one_d = seen_one_q |
                 (sampled_bit && at_sp && in_frame && (state_q != ST_START));
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_in) begin
          state_d   = ST_START;
          par_err_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
          seen_one_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        // A failed start check is a line glitch: drop back silently.
        if (at_ev && start_bit_error) begin
          state_d = ST_IDLE;
        end else if (at_last) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_last && (bit_cnt == BIT_CNT_W'(DATA_WIDTH))) begin
          state_d = par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (at_ev && par_err) begin
          par_err_d = 1'b1;
        end
        if (at_last) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at EV rather than P-1 so a following start bit is not missed.
        if (at_ev) begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (stop_err && !seen_one_q) begin
            break_det_d = 1'b1;
            state_d     = ST_BREAK;
          end else
`endif
          begin
            data_valid_d    = !(par_err_q || stop_err);
            framing_error_d = par_err_q || stop_err;
            state_d         = ST_IDLE;
          end
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      ST_BREAK: begin
        if (rx_in) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Enables are registered from the next state and next edge count so each
  // one is high exactly in the cycle where edge_cnt equals SP.
  always_comb begin
    sampler_en_d   = (state_d != ST_IDLE);
    start_chk_en_d = (state_d == ST_START)  && at_sp_nxt;
    deser_en_d     = (state_d == ST_DATA)   && at_sp_nxt;
    par_chk_en_d   = (state_d == ST_PARITY) && at_sp_nxt;
    stop_chk_en_d  = (state_d == ST_STOP)   && at_sp_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      par_err_q       <= 1'b0;
      sampler_en_q    <= 1'b0;
      start_chk_en_q  <= 1'b0;
      par_chk_en_q    <= 1'b0;
      stop_chk_en_q   <= 1'b0;
      deser_en_q      <= 1'b0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      break_det_q     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      seen_one_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      par_err_q       <= par_err_d;
      sampler_en_q    <= sampler_en_d;
      start_chk_en_q  <= start_chk_en_d;
      par_chk_en_q    <= par_chk_en_d;
      stop_chk_en_q   <= stop_chk_en_d;
      deser_en_q      <= deser_en_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      break_det_q     <= break_det_d;
`ifdef UART_RX_BREAK_DETECT_EN
      seen_one_q      <= seen_one_d;
`endif
    end
  end

  assign sampler_en    = sampler_en_q;
  assign start_chk_en  = start_chk_en_q;
  assign par_chk_en    = par_chk_en_q;
  assign stop_chk_en   = stop_chk_en_q;
  assign deser_en      = deser_en_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign break_det     = break_det_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: frame-offset reference model plus directed and random frames.
// Break expectations follow UART_RX_BREAK_DETECT_EN when it is defined for the build.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = 6'd8;
  logic          par_en = 1'b0;
  logic          sampled_bit;
  logic          start_bit_error = 1'b0;
  logic          par_err = 1'b0;
  logic          stop_err = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          sampler_en, start_chk_en, par_chk_en, stop_chk_en, deser_en;
  logic          data_valid, framing_error, break_det;

  assign sampled_bit = rx_in;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_in           (rx_in),
    .prescale        (prescale),
    .par_en          (par_en),
    .sampled_bit     (sampled_bit),
    .start_bit_error (start_bit_error),
    .par_err         (par_err),
    .stop_err        (stop_err),
    .edge_cnt        (edge_cnt),
    .bit_cnt         (bit_cnt),
    .sampler_en      (sampler_en),
    .start_chk_en    (start_chk_en),
    .par_chk_en      (par_chk_en),
    .stop_chk_en     (stop_chk_en),
    .deser_en        (deser_en),
    .data_valid      (data_valid),
    .framing_error   (framing_error),
    .break_det       (break_det)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_dv = 0, n_fe = 0, n_bk = 0, n_deser = 0, n_start = 0, n_deser_edge_bad = 0;
  int tb_sp = 6;
  bit want_se = 1'b0, want_pe = 1'b0, want_stop = 1'b0;
  logic [2:0] exp_q[$];

  // ---------------- reference model ----------------
  // Tracks position in the frame as a plain cycle offset k: bit = k / P, tick = k % P.
  logic [17:0] exp_vec = '0;
  int m_mode = 0;
  int m_k = 0, m_p = 8, m_pe = 0, m_perr = 0, m_seen = 0;

  always @(posedge clk or posedge reset) begin
    int b, e, sp, ev, stop_idx;
    bit dv, fe, bk;
    if (reset) begin
      m_mode  = 0;
      m_k     = 0;
      exp_vec = '0;
    end else begin
      dv = 1'b0; fe = 1'b0; bk = 1'b0;
      if (m_mode == 0) begin
        if (!rx_in) begin
          m_mode = 1; m_k = 0; m_perr = 0; m_seen = 0;
          m_p = (int'(prescale) < 8) ? 8 : int'(prescale);
        end
      end else if (m_mode == 1) begin
        b = m_k / m_p; e = m_k % m_p; sp = m_p / 2 + 2; ev = sp + 1;
        if (b >= 1 && e == sp && sampled_bit) m_seen = 1;
        if (b == DW && e == m_p - 1) m_pe = int'(par_en);
        stop_idx = DW + 1 + m_pe;
        if (b == 0 && e == ev && start_bit_error) begin
          m_mode = 0;
        end else if (b > DW && b == stop_idx && e == ev) begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (stop_err && m_seen == 0) begin
            bk = 1'b1; m_mode = 2;
          end else
`endif
          begin
            fe = (m_perr != 0) || stop_err;
            dv = !fe;
            m_mode = 0;
          end
        end else begin
          if (m_pe == 1 && b == DW + 1 && e == ev && par_err) m_perr = 1;
          m_k++;
        end
      end else if (rx_in) begin
        m_mode = 0;
      end
      exp_vec = '0;
      exp_vec[2:0] = {dv, fe, bk};
      if (m_mode != 0) exp_vec[7] = 1'b1;
      if (m_mode == 1) begin
        b = m_k / m_p; e = m_k % m_p; sp = m_p / 2 + 2;
        exp_vec[17:12] = 6'(e);
        exp_vec[11:8]  = 4'(b);
        if (e == sp) begin
          if (b == 0) exp_vec[6] = 1'b1;
          else if (b <= DW) exp_vec[3] = 1'b1;
          else if (m_pe == 1 && b == DW + 1) exp_vec[5] = 1'b1;
          else if (b == DW + 1 + m_pe) exp_vec[4] = 1'b1;
        end
      end
      if (dv | fe | bk) exp_q.push_back({dv, fe, bk});
    end
  end

  // ---------------- checker stubs: result one cycle after each enable ----------------
  initial begin
    bit se_prev, pe_prev, st_prev;
    se_prev = 1'b0; pe_prev = 1'b0; st_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      start_bit_error = se_prev && want_se;
      par_err         = pe_prev && want_pe;
      stop_err        = st_prev && want_stop;
      se_prev = start_chk_en;
      pe_prev = par_chk_en;
      st_prev = stop_chk_en;
    end
  end

  // ---------------- per-cycle compare + pulse scoreboard ----------------
  initial begin
    logic [17:0] act;
    logic [2:0]  pv;
    forever begin
      @(negedge clk);
      act = {edge_cnt, bit_cnt, sampler_en, start_chk_en, par_chk_en, stop_chk_en,
             deser_en, data_valid, framing_error, break_det};
      n_cmp++;
      if (act !== exp_vec) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act, exp_vec);
      end
      if (data_valid) n_dv++;
      if (framing_error) n_fe++;
      if (break_det) n_bk++;
      if (start_chk_en) n_start++;
      if (deser_en) begin
        n_deser++;
        if (int'(edge_cnt) != tb_sp) n_deser_edge_bad++;
      end
      if (data_valid | framing_error | break_det) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pulse_scoreboard t=%0t got %b expected none", $time,
                   {data_valid, framing_error, break_det});
        end else begin
          pv = exp_q.pop_front();
          if (pv !== {data_valid, framing_error, break_det}) begin
            n_bad++;
            $display("FAIL pulse_scoreboard t=%0t got %b expected %b", $time,
                     {data_valid, framing_error, break_det}, pv);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [8:0] data, input int p_in, input bit pe,
                            input bit scramble);
    int p;
    p = (p_in < 8) ? 8 : p_in;
    prescale = PW'(p_in);
    par_en   = pe;
    rx_in    = 1'b0;
    wait_clk(p);
    if (scramble) prescale = PW'($urandom_range(0, 63));
    for (int i = 0; i < DW; i++) begin
      rx_in = data[i];
      wait_clk(p);
    end
    if (pe) begin
      rx_in = ^data[DW-1:0];
      wait_clk(p);
    end
    rx_in = 1'b1;
    wait_clk(p);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s_dv, s_fe, s_bk, s_de, s_deb, s_st, p;
    wait_clk(3);
    check("reset_edge_cnt", int'(edge_cnt), 0);
    check("reset_bit_cnt", int'(bit_cnt), 0);
    check("reset_sampler_en", int'(sampler_en), 0);
    check("reset_data_valid", int'(data_valid), 0);
    reset = 1'b0;
    wait_clk(2);

    // 1: P=8, no parity, 0xA5
    tb_sp = 6;
    s_dv = n_dv; s_fe = n_fe; s_de = n_deser; s_deb = n_deser_edge_bad;
    send_frame(9'h0A5, 8, 1'b0, 1'b0);
    wait_clk(4);
    check("t1_deser_pulses", n_deser - s_de, 8);
    check("t1_deser_at_edge6", n_deser_edge_bad - s_deb, 0);
    check("t1_data_valid", n_dv - s_dv, 1);
    check("t1_framing_error", n_fe - s_fe, 0);

    // 2: P=16, parity error
    want_pe = 1'b1;
    s_dv = n_dv; s_fe = n_fe;
    send_frame(9'h03C, 16, 1'b1, 1'b0);
    wait_clk(4);
    want_pe = 1'b0;
    check("t2_framing_error", n_fe - s_fe, 1);
    check("t2_data_valid", n_dv - s_dv, 0);

    // 3: start-bit glitch
    want_se = 1'b1;
    s_dv = n_dv; s_fe = n_fe; s_de = n_deser; s_st = n_start;
    prescale = 6'd16;
    rx_in = 1'b0;
    wait_clk(3);
    rx_in = 1'b1;
    wait_clk(40);
    want_se = 1'b0;
    check("t3_start_chk_once", n_start - s_st, 1);
    check("t3_no_deser", n_deser - s_de, 0);
    check("t3_no_pulses", (n_dv - s_dv) + (n_fe - s_fe), 0);
    check("t3_back_idle", int'(sampler_en), 0);

    // 4: back-to-back frames at P=8
    s_dv = n_dv;
    send_frame(9'h055, 8, 1'b0, 1'b0);
    send_frame(9'h0F0, 8, 1'b0, 1'b0);
    wait_clk(4);
    check("t4_two_valid", n_dv - s_dv, 2);

    // 5: reset during data bit 4
    fork
      send_frame(9'h03C, 16, 1'b0, 1'b0);
      begin
        wait_clk(16 * 5 + 6);
        reset = 1'b1;
        #1;
        check("t5_reset_sampler_en", int'(sampler_en), 0);
        check("t5_reset_bit_cnt", int'(bit_cnt), 0);
        check("t5_reset_edge_cnt", int'(edge_cnt), 0);
        wait_clk(1);
        reset = 1'b0;
      end
    join
    wait_clk(200);
    s_dv = n_dv; s_fe = n_fe;
    send_frame(9'h05A, 16, 1'b0, 1'b0);
    wait_clk(4);
    check("t5_next_frame_valid", n_dv - s_dv, 1);
    check("t5_next_frame_no_fe", n_fe - s_fe, 0);

    // 6: line held low for two frame times
    want_stop = 1'b1;
    s_fe = n_fe; s_bk = n_bk;
    prescale = 6'd8;
    par_en = 1'b0;
    rx_in = 1'b0;
    wait_clk(160);
`ifdef UART_RX_BREAK_DETECT_EN
    check("t6_break_pulse", n_bk - s_bk, 1);
    check("t6_no_framing_error", n_fe - s_fe, 0);
    check("t6_held_in_break", int'(sampler_en), 1);
`else
    check("t6_no_break", n_bk - s_bk, 0);
    check("t6_framing_error_seen", int'((n_fe - s_fe) > 0), 1);
`endif
    rx_in = 1'b1;
    wait_clk(100);
    want_stop = 1'b0;
    check("t6_idle_after_line_high", int'(sampler_en), 0);

    // randomized frames
    s_dv = n_dv;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: p = 4;
        1: p = 8;
        2: p = 12;
        3: p = 16;
        default: p = 32;
      endcase
      want_se   = ($urandom_range(0, 9) == 0);
      want_pe   = ($urandom_range(0, 3) == 0);
      want_stop = ($urandom_range(0, 4) == 0);
      send_frame(9'($urandom), p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_clk($urandom_range(0, 3));
    end
    want_se = 1'b0; want_pe = 1'b0; want_stop = 1'b0;
    rx_in = 1'b1;
    wait_clk(400);
    check("rand_some_valid", int'((n_dv - s_dv) > 0), 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
